// File: rtl/sq_pkg.sv
// sq_pkg: constants shared by the 1011 sequence path (serializer and detector).
// Defining SQ_SER_PARITY_EN adds the serializer PARITY state.
package sq_pkg;

  // Parallel word width used when the serializer is instantiated without override
  localparam int SQ_DEFAULT_WIDTH = 8;

  // Serializer FSM encodings
  typedef enum logic [1:0] {
    SER_IDLE   = 2'b00,
    SER_SHIFT  = 2'b01
`ifdef SQ_SER_PARITY_EN
    , SER_PARITY = 2'b10
`endif
  } ser_state_t;

  // 1011 detector FSM encodings, named after the prefix matched so far
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_t;

endpackage

// File: rtl/sq_serializer.sv
// sq_serializer: MSB-first parallel-to-serial converter feeding the 1011 detector.
// Words are taken on a P_valid/P_ready handshake and streamed one bit per cycle.
// Defining SQ_SER_PARITY_EN appends one even-parity bit after each word;
// without it consecutive words stream back to back with no gap.
module sq_serializer
  import sq_pkg::*;
#(
  parameter int WIDTH = SQ_DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] P_data,
  input  logic             P_valid,
  output logic             P_ready,
  output logic             S_output,
  output logic             S_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_next;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             accept;

`ifdef SQ_SER_PARITY_EN
  logic             par_bit;
`endif

  assign accept = P_valid && P_ready;

  // Next state, handshake ready and serial outputs all decoded from the current state
  always_comb begin
    state_next = state;
    P_ready    = 1'b0;
    S_valid    = 1'b0;
    S_output   = 1'b0;
    case (state)
      SER_IDLE: begin
        P_ready = 1'b1;
        if (P_valid) begin
          state_next = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        S_valid  = 1'b1;
        S_output = shreg[WIDTH-1];
        if (cnt == '0) begin
`ifdef SQ_SER_PARITY_EN
          state_next = SER_PARITY;
`else
          P_ready    = 1'b1;
          state_next = P_valid ? SER_SHIFT : SER_IDLE;
`endif
        end
      end
`ifdef SQ_SER_PARITY_EN
      SER_PARITY: begin
        S_valid    = 1'b1;
        S_output   = par_bit;
        P_ready    = 1'b1;
        state_next = P_valid ? SER_SHIFT : SER_IDLE;
      end
`endif
      default: begin
        state_next = SER_IDLE;
      end
    endcase
  end

  // State register; reset drops straight to IDLE so a partial word is abandoned
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= SER_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register and bit counter: load on acceptance, otherwise shift while streaming
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= P_data;
      cnt   <= LAST_IDX;
    end else if (state == SER_SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef SQ_SER_PARITY_EN
  // Even parity of the accepted word, captured at load so later P_data changes cannot disturb it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^P_data;
    end
  end
`endif

endmodule

// File: tb/tb_sq_serializer.sv
// tb_sq_serializer: directed self-checking bench for sq_serializer (WIDTH=8).
// Honours SQ_SER_PARITY_EN so the same bench covers both stream formats.
module tb_sq_serializer;

  localparam int WIDTH = 8;
`ifdef SQ_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N = WIDTH + PAR;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [WIDTH-1:0] P_data = '0;
  logic             P_valid = 1'b0;
  logic             P_ready;
  logic             S_output;
  logic             S_valid;

  int checks = 0;
  int errors = 0;

  logic [3:0] hist;
  int         det_count = 0;

  // 10 time-unit clock
  always #5 CLK = ~CLK;

  sq_serializer #(.WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .P_data   (P_data),
    .P_valid  (P_valid),
    .P_ready  (P_ready),
    .S_output (S_output),
    .S_valid  (S_valid)
  );

  // Reference overlapping 1011 detector on the serial stream, sampled mid-cycle
  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist <= 4'b0000;
    end else if (S_valid) begin
      hist <= {hist[2:0], S_output};
      if ({hist[2:0], S_output} == 4'b1011) begin
        det_count <= det_count + 1;
      end
    end
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N   = 1'b0;
    P_valid = 1'b0;
    P_data  = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (P_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_p_ready: got %b expected 1", P_ready);
    end
    checks++;
    if (S_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s_valid: got %b expected 0", S_valid);
    end
    checks++;
    if (S_output !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s_output: got %b expected 0", S_output);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single_word();
    logic [WIDTH-1:0] word;
    int det_before;
    word       = 8'hB0;
    det_before = det_count;
    P_data     = word;
    P_valid    = 1'b1;
    step();
    P_valid = 1'b0;
    P_data  = 8'h00;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (S_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL single_s_valid[%0d]: got %b expected 1", i, S_valid);
      end
      checks++;
      if (S_output !== word[WIDTH-1-i]) begin
        errors++;
        $display("[TB] FAIL single_bit[%0d]: got %b expected %b", i, S_output, word[WIDTH-1-i]);
      end
      checks++;
      if (P_ready !== 1'((i == WIDTH - 1) && (PAR == 0))) begin
        errors++;
        $display("[TB] FAIL single_p_ready[%0d]: got %b expected %b", i, P_ready,
                 1'((i == WIDTH - 1) && (PAR == 0)));
      end
      step();
    end
`ifdef SQ_SER_PARITY_EN
    checks++;
    if (S_valid !== 1'b1 || S_output !== 1'b1 || P_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_parity: got valid=%b bit=%b ready=%b expected 1 1 1",
               S_valid, S_output, P_ready);
    end
    step();
`endif
    checks++;
    if (S_valid !== 1'b0 || S_output !== 1'b0 || P_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_idle: got valid=%b bit=%b ready=%b expected 0 0 1",
               S_valid, S_output, P_ready);
    end
    checks++;
    if (det_count - det_before !== 1) begin
      errors++;
      $display("[TB] FAIL single_detect: got %0d pulses expected 1", det_count - det_before);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] exp_stream;
`ifdef SQ_SER_PARITY_EN
    exp_stream = {8'hB0, 1'b1, 8'h0B, 1'b1};
`else
    exp_stream = {8'hB0, 8'h0B};
`endif
    P_data  = 8'hB0;
    P_valid = 1'b1;
    step();
    P_data = 8'h0B;
    for (int j = 0; j < 2 * N; j++) begin
      checks++;
      if (S_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_s_valid[%0d]: got %b expected 1", j, S_valid);
      end
      checks++;
      if (S_output !== exp_stream[2*N-1-j]) begin
        errors++;
        $display("[TB] FAIL b2b_bit[%0d]: got %b expected %b", j, S_output, exp_stream[2*N-1-j]);
      end
      checks++;
      if (P_ready !== 1'((j % N) == N - 1)) begin
        errors++;
        $display("[TB] FAIL b2b_p_ready[%0d]: got %b expected %b", j, P_ready, 1'((j % N) == N - 1));
      end
      if (j == N) begin
        P_valid = 1'b0;
      end
      step();
    end
    checks++;
    if (S_valid !== 1'b0 || P_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got valid=%b ready=%b expected 0 1", S_valid, P_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [WIDTH-1:0] word;
    P_data  = 8'hFF;
    P_valid = 1'b1;
    step();
    P_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (S_valid !== 1'b1 || S_output !== 1'b1) begin
        errors++;
        $display("[TB] FAIL midrst_pre[%0d]: got valid=%b bit=%b expected 1 1", i, S_valid, S_output);
      end
      step();
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (S_valid !== 1'b0 || S_output !== 1'b0 || P_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_async: got valid=%b bit=%b ready=%b expected 0 0 1",
               S_valid, S_output, P_ready);
    end
    step();
    checks++;
    if (S_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_held: got %b expected 0", S_valid);
    end
    RST_N   = 1'b1;
    word    = 8'h80;
    P_data  = word;
    P_valid = 1'b1;
    step();
    P_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (S_valid !== 1'b1 || S_output !== word[WIDTH-1-i]) begin
        errors++;
        $display("[TB] FAIL midrst_bit[%0d]: got valid=%b bit=%b expected 1 %b",
                 i, S_valid, S_output, word[WIDTH-1-i]);
      end
      step();
    end
`ifdef SQ_SER_PARITY_EN
    checks++;
    if (S_valid !== 1'b1 || S_output !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_parity: got valid=%b bit=%b expected 1 1", S_valid, S_output);
    end
    step();
`endif
    checks++;
    if (S_valid !== 1'b0 || S_output !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_idle: got valid=%b bit=%b expected 0 0", S_valid, S_output);
    end
  endtask

  task automatic test_idle();
    RST_N   = 1'b0;
    P_valid = 1'b0;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (P_ready !== 1'b1 || S_valid !== 1'b0 || S_output !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle[%0d]: got ready=%b valid=%b bit=%b expected 1 0 0",
                 i, P_ready, S_valid, S_output);
      end
      step();
    end
  endtask

  task automatic test_data_toggle();
    logic [WIDTH-1:0] word;
    word    = 8'h5C;
    P_data  = word;
    P_valid = 1'b1;
    step();
    P_valid = 1'b0;
    P_data  = 8'hA3;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (S_valid !== 1'b1 || S_output !== word[WIDTH-1-i]) begin
        errors++;
        $display("[TB] FAIL toggle_bit[%0d]: got valid=%b bit=%b expected 1 %b",
                 i, S_valid, S_output, word[WIDTH-1-i]);
      end
      P_data = ~P_data;
      step();
    end
`ifdef SQ_SER_PARITY_EN
    checks++;
    if (S_valid !== 1'b1 || S_output !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_parity: got valid=%b bit=%b expected 1 0", S_valid, S_output);
    end
    step();
`endif
    checks++;
    if (S_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_idle: got %b expected 0", S_valid);
    end
  endtask

`ifdef SQ_SER_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] word;
    word    = 8'h33;
    P_data  = word;
    P_valid = 1'b1;
    step();
    P_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (S_valid !== 1'b1 || S_output !== word[WIDTH-1-i]) begin
        errors++;
        $display("[TB] FAIL parity_bit[%0d]: got valid=%b bit=%b expected 1 %b",
                 i, S_valid, S_output, word[WIDTH-1-i]);
      end
      step();
    end
    checks++;
    if (S_valid !== 1'b1 || S_output !== 1'b0 || P_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_even: got valid=%b bit=%b ready=%b expected 1 0 1",
               S_valid, S_output, P_ready);
    end
    step();
    checks++;
    if (S_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL parity_idle: got %b expected 0", S_valid);
    end
  endtask
`endif

  // Scenario sequence
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_reset_mid_word();
    test_idle();
    test_data_toggle();
`ifdef SQ_SER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
